// File: rtl/gray_pdm_selector_pkg.sv
// rtl/gray_pdm_selector_pkg.sv - shared sizing helpers for the gray-slot PDM selector
package gray_pdm_selector_pkg;

  // Width of the trailing-ones slot index, which ranges over 0..w.
  function automatic int slot_idx_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Width of a bit index into a w-bit data word.
  function automatic int bit_sel_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/trail_ones_enc.sv
// rtl/trail_ones_enc.sv - trailing-ones priority encoder for the gray slot index
module trail_ones_enc #(
  parameter int WIDTH = 10,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] cnt,
  output logic [KW-1:0]    k
);

  // The lowest zero bit of cnt is the bit that toggles on the next increment.
  always_comb begin
    k = KW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!cnt[i]) k = KW'(i);
    end
  end

endmodule

// File: rtl/gray_pdm_selector.sv
// rtl/gray_pdm_selector.sv - multi-channel gray-slot bit-serial PDM selector
module gray_pdm_selector
  import gray_pdm_selector_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int NCH    = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic                   upd_en,
  input  logic [NCH*WIDTH-1:0]   in,
  output logic [NCH-1:0]         out_muxed,
  output logic                   frame_start,
  output logic                   loaded
);

  localparam int              KW      = slot_idx_w(WIDTH);
  localparam int              SW      = bit_sel_w(WIDTH);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] FLIP    = SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  logic [WIDTH-1:0]            cnt;
  logic [KW-1:0]               k;
  logic                        idle;
  logic [SW-1:0]               sel;
  logic                        wrap;
  logic [NCH-1:0][WIDTH-1:0]   data_q;
  logic [NCH-1:0][WIDTH-1:0]   load_word;
  logic [NCH-1:0]              out_next;

  trail_ones_enc #(.WIDTH(WIDTH), .KW(KW)) u_enc (
    .cnt (cnt),
    .k   (k)
  );

  assign idle = (k == KW'(WIDTH));
  assign sel  = SW'(KW'(WIDTH - 1) - k);
  assign wrap = (cnt == CNT_MAX);

  // Signed words become offset binary so density still tracks the value.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign load_word[c] = in[c*WIDTH +: WIDTH] ^ FLIP;
    assign out_next[c]  = idle ? 1'b0 : data_q[c][sel];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt         <= '0;
      data_q      <= '0;
      out_muxed   <= '0;
      frame_start <= 1'b0;
      loaded      <= 1'b0;
    end else if (en) begin
      out_muxed   <= out_next;
      frame_start <= (cnt == '0);
      cnt         <= cnt + WIDTH'(1);
      // Shadow load only at the frame boundary keeps each frame's density intact.
      if (wrap && upd_en) begin
        data_q <= load_word;
        loaded <= 1'b1;
      end else begin
        loaded <= 1'b0;
      end
    end else begin
      out_muxed   <= '0;
      frame_start <= 1'b0;
      loaded      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_pdm_selector.sv
// tb/tb_gray_pdm_selector.sv - self-checking bench for gray_pdm_selector
module tb_gray_pdm_selector;

  localparam int W = 4;

  typedef struct packed {
    logic [1:0] out;
    logic       fs;
    logic       ld;
    logic       sout;
    logic       sfs;
    logic       sld;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstb, en, upd_en;
  logic [7:0] din;
  logic [1:0] out_muxed;
  logic       frame_start, loaded;
  logic       s_en, s_upd;
  logic [3:0] s_in;
  logic [0:0] s_out;
  logic       s_fs, s_ld;

  int         n_chk  = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  int         m_cnt, ms_cnt;
  logic [3:0] m_data [2];
  logic [3:0] ms_data;
  logic [15:0] rec0, rec1, srec;
  int         ld_cnt;

  always #5 clk = ~clk;

  gray_pdm_selector #(.WIDTH(W), .NCH(2), .SIGNED(1'b0)) dut (
    .clk(clk), .rstb(rstb), .en(en), .upd_en(upd_en), .in(din),
    .out_muxed(out_muxed), .frame_start(frame_start), .loaded(loaded)
  );

  gray_pdm_selector #(.WIDTH(W), .NCH(1), .SIGNED(1'b1)) sdut (
    .clk(clk), .rstb(rstb), .en(s_en), .upd_en(s_upd), .in(s_in),
    .out_muxed(s_out), .frame_start(s_fs), .loaded(s_ld)
  );

  // Slot n carries data bit W-1-k where n mod 2^(k+1) == 2^k - 1; otherwise idle.
  function automatic logic exp_bit(input logic [3:0] w, input int n);
    for (int k = 0; k < W; k++) begin
      if ((n % (1 << (k + 1))) == ((1 << k) - 1)) return w[W-1-k];
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    int   pc, ps;
    logic was_en, was_sen;
    e      = '0;
    pc     = m_cnt;
    ps     = ms_cnt;
    was_en = en;
    was_sen = s_en;
    if (en) begin
      e.out = {exp_bit(m_data[1], m_cnt), exp_bit(m_data[0], m_cnt)};
      e.fs  = (m_cnt == 0);
      e.ld  = (m_cnt == 15) && upd_en;
      if (e.ld) begin
        m_data[0] = din[3:0];
        m_data[1] = din[7:4];
      end
      m_cnt = (m_cnt + 1) % 16;
    end
    if (s_en) begin
      e.sout = exp_bit(ms_data, ms_cnt);
      e.sfs  = (ms_cnt == 0);
      e.sld  = (ms_cnt == 15) && s_upd;
      if (e.sld) ms_data = s_in ^ 4'b1000;
      ms_cnt = (ms_cnt + 1) % 16;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out_muxed", 32'(out_muxed), 32'(e.out));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("loaded", 32'(loaded), 32'(e.ld));
    chk("s_out_muxed", 32'(s_out), 32'(e.sout));
    chk("s_frame_start", 32'(s_fs), 32'(e.sfs));
    chk("s_loaded", 32'(s_ld), 32'(e.sld));
    if (was_en) begin
      rec0[pc] = out_muxed[0];
      rec1[pc] = out_muxed[1];
    end
    if (was_sen) srec[ps] = s_out[0];
    if (loaded) ld_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_rec();
    rec0   = '0;
    rec1   = '0;
    srec   = '0;
    ld_cnt = 0;
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    ms_cnt    = 0;
    m_data[0] = '0;
    m_data[1] = '0;
    ms_data   = '0;
  endtask

  initial begin
    rstb = 1'b0; en = 1'b0; upd_en = 1'b0; din = '0;
    s_en = 1'b0; s_upd = 1'b0; s_in = '0;
    model_reset();
    clr_rec();
    #12;
    chk("reset_out", 32'(out_muxed), 32'd0);
    chk("reset_fs", 32'(frame_start), 32'd0);
    chk("reset_ld", 32'(loaded), 32'd0);
    chk("reset_s_out", 32'(s_out), 32'd0);

    // Frame 0 after reset is all zero; words 5/8 and signed -8 load at its end.
    @(negedge clk);
    rstb = 1'b1; en = 1'b1; upd_en = 1'b1; din = {4'd8, 4'd5};
    s_en = 1'b1; s_upd = 1'b1; s_in = 4'b1000;
    clr_rec();
    run(16);
    chk("frame0_ch0", 32'(rec0), 32'h0000);
    chk("frame0_ch1", 32'(rec1), 32'h0000);
    chk("frame0_loaded", 32'(ld_cnt), 32'd1);

    s_in = 4'd0;
    clr_rec();
    run(16);
    chk("word5_pattern", 32'(rec0), 32'h22A2);
    chk("word8_pattern", 32'(rec1), 32'h5555);
    chk("word5_density", 32'($countones(rec0)), 32'd5);
    chk("signed_m8_density", 32'($countones(srec)), 32'd0);

    din[3:0] = 4'd15;
    s_in = 4'd7;
    clr_rec();
    run(16);
    chk("signed_0_density", 32'($countones(srec)), 32'd8);
    chk("frame2_loaded", 32'(ld_cnt), 32'd1);

    din[3:0] = 4'd0;
    clr_rec();
    run(16);
    chk("word15_pattern", 32'(rec0), 32'h7FFF);
    chk("signed_7_density", 32'($countones(srec)), 32'd15);
    chk("frame3_loaded", 32'(ld_cnt), 32'd1);

    din[3:0] = 4'd5;
    clr_rec();
    run(16);
    chk("word0_pattern", 32'(rec0), 32'h0000);

    // Mid-frame change at cnt 6 must not disturb the running frame.
    clr_rec();
    run(6);
    din[3:0] = 4'd8;
    run(10);
    chk("midframe_hold", 32'(rec0), 32'h22A2);

    clr_rec();
    run(16);
    chk("midframe_next", 32'(rec0), 32'h5555);

    // Pause at cnt 9 for 7 cycles; the frame must resume where it stopped.
    clr_rec();
    run(9);
    en = 1'b0;
    run(7);
    en = 1'b1;
    run(7);
    chk("pause_pattern", 32'(rec0), 32'h5555);
    chk("pause_density", 32'($countones(rec1)), 32'd8);

    // Asynchronous reset at cnt 11, checked before the next clock edge.
    run(11);
    #2;
    rstb = 1'b0;
    #1;
    chk("async_rst_out", 32'(out_muxed), 32'd0);
    chk("async_rst_fs", 32'(frame_start), 32'd0);
    chk("async_rst_ld", 32'(loaded), 32'd0);
    chk("async_rst_s_out", 32'(s_out), 32'd0);
    model_reset();
    @(negedge clk);
    rstb = 1'b1;
    clr_rec();
    step();
    chk("post_rst_fs", 32'(frame_start), 32'd1);
    run(15);
    chk("post_rst_ch0", 32'(rec0), 32'h0000);
    chk("post_rst_ch1", 32'(rec1), 32'h0000);

    clr_rec();
    run(16);
    chk("post_rst_reload", 32'(rec0), 32'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
